// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver: decodes scan-code set 2 make codes into uppercase ASCII with a 1-based position.
// Build option: define PS2_BACKSPACE_EN to make scan code 0x66 a backspace key (letter 0x08, position steps back).
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_COUNT      = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       lvl_won,
  output logic [7:0] letter,
  output logic [7:0] counter,
  output logic       key_valid,
  output logic       frame_err,
  output logic [1:0] fsm_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_CNT = 8'(MAX_COUNT);

  // Handshake: key_valid and frame_err are single-cycle pulses with no back-pressure; letter/counter
  // are valid whenever key_valid is high and hold their value otherwise.

  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic fall, bit_in;

  logic [1:0]      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            byte_ok, frame_bad;

  logic       brk_q, brk_d;
  logic       ext_q, ext_d;
  logic [7:0] held_q, held_d;
  logic       accept;
  logic       code_mapped;
  logic [7:0] code_ascii;
  logic       is_bs;

  logic [7:0] letter_q, counter_q;
  logic       key_valid_q, frame_err_q;

  function automatic logic [8:0] map_code(input logic [7:0] c);
    logic [8:0] r;
    r = 9'h000;
    case (c)
      8'h1C: r = {1'b1, 8'h41};
      8'h32: r = {1'b1, 8'h42};
      8'h21: r = {1'b1, 8'h43};
      8'h23: r = {1'b1, 8'h44};
      8'h24: r = {1'b1, 8'h45};
      8'h2B: r = {1'b1, 8'h46};
      8'h34: r = {1'b1, 8'h47};
      8'h33: r = {1'b1, 8'h48};
      8'h43: r = {1'b1, 8'h49};
      8'h3B: r = {1'b1, 8'h4A};
      8'h42: r = {1'b1, 8'h4B};
      8'h4B: r = {1'b1, 8'h4C};
      8'h3A: r = {1'b1, 8'h4D};
      8'h31: r = {1'b1, 8'h4E};
      8'h44: r = {1'b1, 8'h4F};
      8'h4D: r = {1'b1, 8'h50};
      8'h15: r = {1'b1, 8'h51};
      8'h2D: r = {1'b1, 8'h52};
      8'h1B: r = {1'b1, 8'h53};
      8'h2C: r = {1'b1, 8'h54};
      8'h3C: r = {1'b1, 8'h55};
      8'h2A: r = {1'b1, 8'h56};
      8'h1D: r = {1'b1, 8'h57};
      8'h22: r = {1'b1, 8'h58};
      8'h35: r = {1'b1, 8'h59};
      8'h1A: r = {1'b1, 8'h5A};
      8'h29: r = {1'b1, 8'h20};
`ifdef PS2_BACKSPACE_EN
      8'h66: r = {1'b1, 8'h08};
`endif
      default: r = 9'h000;
    endcase
    return r;
  endfunction

`ifdef PS2_BACKSPACE_EN
  assign is_bs = (shift_q == 8'h66);
`else
  assign is_bs = 1'b0;
`endif

  // Synchronisers idle high so reset never manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall   = clk_s3_q & ~clk_s2_q;
  assign bit_in = dat_s2_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    wd_d      = '0;
    byte_ok   = 1'b0;
    frame_bad = 1'b0;
    if (state_q != ST_IDLE) wd_d = fall ? '0 : wd_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (fall && !bit_in) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = bit_in;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if ((^{shift_q, par_q}) && bit_in) byte_ok = 1'b1;
          else frame_bad = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A keyboard that stops clocking mid-frame must not wedge the receiver.
    if (state_q != ST_IDLE && !fall && wd_q == WD_LAST) begin
      state_d   = ST_IDLE;
      frame_bad = 1'b1;
      wd_d      = '0;
    end
  end

  always_comb begin
    brk_d  = brk_q;
    ext_d  = ext_q;
    held_d = held_q;
    accept = 1'b0;
    {code_mapped, code_ascii} = map_code(shift_q);
    if (byte_ok) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q || ext_q) begin
        if (brk_q && shift_q == held_q) held_d = 8'h00;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else if (shift_q != held_q && code_mapped) begin
        held_d = shift_q;
        accept = 1'b1;
      end
    end
    if (lvl_won) held_d = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      wd_q        <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      held_q      <= 8'h00;
      letter_q    <= 8'h00;
      counter_q   <= 8'h00;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      wd_q        <= wd_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      held_q      <= held_d;
      key_valid_q <= 1'b0;
      frame_err_q <= frame_bad;
      if (lvl_won) begin
        letter_q  <= 8'h00;
        counter_q <= 8'h00;
      end else if (accept) begin
        letter_q    <= code_ascii;
        key_valid_q <= 1'b1;
        if (is_bs) counter_q <= (counter_q == 8'h00) ? 8'h00 : counter_q - 8'd1;
        else       counter_q <= (counter_q >= MAX_CNT) ? MAX_CNT : counter_q + 8'd1;
      end
    end
  end

  assign letter    = letter_q;
  assign counter   = counter_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: PS/2 frame driver, keystroke-level reference model, per-cycle compare.
module tb_ps2_key_tracker;

  localparam int TO_CYC = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       lvl_won = 1'b0;
  logic [7:0] letter, counter;
  logic       key_valid, frame_err;
  logic [1:0] fsm_state;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO_CYC), .MAX_COUNT(15)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .lvl_won(lvl_won),
    .letter(letter), .counter(counter), .key_valid(key_valid), .frame_err(frame_err),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  int err_seen = 0, exp_err = 0, kv_seen = 0;
  logic [7:0] sh_letter = 8'h00, sh_cnt = 8'h00;
  logic rst_s = 1'b1, won_s = 1'b0;

  // Keystroke-level model state.
  int m_cnt = 0;
  logic [7:0] m_held = 8'h00;
  bit m_brk = 0, m_ext = 0;

  logic [7:0] pool[27] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                           8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                           8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A, 8'h29};
  string abc = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Letters are looked up by their position in the pool (pool order is A..Z then space).
  function automatic bit m_lookup(input logic [7:0] code, output logic [7:0] ascii);
    ascii = 8'h00;
    for (int i = 0; i < 26; i++) if (pool[i] == code) begin ascii = abc[i]; return 1; end
    if (code == 8'h29) begin ascii = 8'h20; return 1; end
`ifdef PS2_BACKSPACE_EN
    if (code == 8'h66) begin ascii = 8'h08; return 1; end
`endif
    return 0;
  endfunction

  task automatic m_byte(input logic [7:0] code, input bit clr);
    logic [7:0] a;
    bit ok;
    ok = m_lookup(code, a);
    if (code == 8'hE0) m_ext = 1;
    else if (code == 8'hF0) m_brk = 1;
    else if (m_brk || m_ext) begin
      if (m_brk && code == m_held) m_held = 8'h00;
      m_brk = 0; m_ext = 0;
    end else if (code != m_held && ok && !clr) begin
      m_held = code;
      if (a == 8'h08) m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
      else m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
      exp_q.push_back({a, 8'(m_cnt)});
    end
    if (clr) begin m_held = 8'h00; m_cnt = 0; end
  endtask

  always @(posedge clk) begin
    rst_s <= reset;
    won_s <= lvl_won;
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_s) begin
      check("reset_out", {letter, counter, key_valid, frame_err}, 0);
      sh_letter = 8'h00; sh_cnt = 8'h00;
    end else begin
      if (frame_err) err_seen++;
      if (key_valid) kv_seen++;
      if (won_s) begin
        check("clear_out", {letter, counter, key_valid}, 0);
        sh_letter = 8'h00; sh_cnt = 8'h00;
      end else if (key_valid) begin
        if (exp_q.size() == 0) check("unexpected_key", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("key_letter", letter, e[15:8]);
          check("key_count", counter, e[7:0]);
          sh_letter = e[15:8]; sh_cnt = e[7:0];
        end
      end else begin
        check("hold_letter", letter, sh_letter);
        check("hold_count", counter, sh_cnt);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_clk(4);
    ps2_clk = 1'b0;
    wait_clk(8);
    ps2_clk = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit flip, input bit won_at_stop);
    if (flip) exp_err++;
    else m_byte(code, won_at_stop);
    if (flip && won_at_stop) begin m_held = 8'h00; m_cnt = 0; end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ flip);
    if (won_at_stop) lvl_won = 1'b1;
    send_bit(1'b1);
    lvl_won = 1'b0;
    wait_clk(4);
    check("frame_err_count", err_seen, exp_err);
  endtask

  task automatic pulse_won();
    lvl_won = 1'b1;
    wait_clk(1);
    lvl_won = 1'b0;
    wait_clk(2);
    m_held = 8'h00; m_cnt = 0;
  endtask

  initial begin
    int kv0;
    logic [7:0] c, last;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    check("reset_letter", letter, 8'h00);
    check("reset_counter", counter, 8'h00);
    check("reset_state", fsm_state, 2'd0);

    // Single good frame 0x32 -> 'B' at position 1.
    send_frame(8'h32, 0, 0);
    check("b_letter", letter, 8'h42);
    check("b_counter", counter, 8'd1);
    check("b_err", err_seen, 0);

    // Typematic repeats and a release.
    pulse_won();
    kv0 = kv_seen;
    foreach (pool[i]) if (i < 0) c = pool[i];
    send_frame(8'h32, 0, 0); send_frame(8'h32, 0, 0); send_frame(8'h32, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h32, 0, 0); send_frame(8'h32, 0, 0);
    check("typematic_accepts", kv_seen - kv0, 2);
    check("typematic_counter", counter, 8'd2);
    check("typematic_letter", letter, 8'h42);

    // Parity error leaves outputs untouched.
    send_frame(8'h3C, 1, 0);
    check("parity_err", err_seen, 1);
    check("parity_counter", counter, 8'd2);
    check("parity_letter", letter, 8'h42);
    send_frame(8'h3C, 0, 0);
    check("u_letter", letter, 8'h55);

    // Saturation over 16 press/release pairs.
    pulse_won();
    kv0 = kv_seen;
    for (int i = 0; i < 16; i++) begin
      send_frame(pool[i], 0, 0); send_frame(8'hF0, 0, 0); send_frame(pool[i], 0, 0);
    end
    check("sat_accepts", kv_seen - kv0, 16);
    check("sat_counter", counter, 8'd15);
    check("sat_letter", letter, 8'h50);

    // Clear and the dropped accept.
    pulse_won();
    for (int i = 0; i < 5; i++) send_frame(pool[i], 0, 0);
    check("pre_clear_counter", counter, 8'd5);
    pulse_won();
    check("clear_counter", counter, 8'd0);
    check("clear_letter", letter, 8'h00);
    send_frame(8'h29, 0, 0);
    check("space_letter", letter, 8'h20);
    check("space_counter", counter, 8'd1);
    kv0 = kv_seen;
    send_frame(8'h1C, 0, 1);
    check("won_drop_kv", kv_seen - kv0, 0);
    check("won_drop_counter", counter, 8'd0);

    // Extended codes never accept.
    kv0 = kv_seen;
    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'h1C, 0, 0);
    check("ext_accepts", kv_seen - kv0, 0);

    // Watchdog abandons a stalled frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    exp_err++;
    wait_clk(TO_CYC + 30);
    check("timeout_err", err_seen, exp_err);
    check("timeout_state", fsm_state, 2'd0);
    send_frame(8'h24, 0, 0);
    check("post_timeout_letter", letter, 8'h45);

    // Reset mid-frame loses the frame silently.
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    reset = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    m_held = 8'h00; m_cnt = 0; m_brk = 0; m_ext = 0;
    wait_clk(TO_CYC + 30);
    check("rst_mid_state", fsm_state, 2'd0);
    check("rst_mid_err", err_seen, exp_err);
    send_frame(8'h1C, 0, 0);
    check("rst_mid_counter", counter, 8'd1);

    // Random keystroke traffic.
    last = 8'h1C;
    for (int n = 0; n < 70; n++) begin
      case ($urandom_range(0, 9))
        0: c = 8'hF0;
        1: c = 8'hE0;
        2: c = last;
        3: c = 8'($urandom_range(0, 255));
`ifdef PS2_BACKSPACE_EN
        4: c = 8'h66;
`endif
        default: c = pool[$urandom_range(0, 26)];
      endcase
      if (c != 8'hF0 && c != 8'hE0) last = c;
      send_frame(c, $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) pulse_won();
    end

    wait_clk(20);
    check("pending_keys", exp_q.size(), 0);
    check("final_err", err_seen, exp_err);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Upstream input stage for the typing-game level displays. It receives raw PS/2 keyboard traffic and decodes scan-code set 2 make codes into uppercase ASCII.
- It presents each accepted keystroke as `letter` together with a 1-based position `counter`. The level display compares these against its hardcoded target string.
- `counter` is cleared when the display asserts `lvl_won`, so the next level starts at position 1.

Parameters:
- TIMEOUT_CYCLES, 100000: clk cycles without a PS/2 falling edge mid-frame before the frame is abandoned (1 ms at 100 MHz).
- MAX_COUNT, 15: saturation value of `counter`.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- ps2_clk  input  1  raw keyboard clock (asynchronous)
- ps2_data  input  1  raw keyboard data (asynchronous)
- lvl_won  input  1  level-complete flag from the display; clears the position
- letter  output  8  ASCII of the last accepted key
- counter  output  8  number of accepted keys since reset or clear
- key_valid  output  1  one-cycle pulse when `letter`/`counter` update
- frame_err  output  1  one-cycle pulse on a parity or stop-bit error, or on a timeout

Behaviour:
- Reset values: letter=0x00, counter=0, key_valid=0, frame_err=0. Reset also clears the internal FSM to IDLE and clears the break, extended and held-code state.
- Input synchronisation:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - A falling edge is detected when the synced clock's previous value is 1 and its current value is 0.
  - Data is sampled on the falling-edge cycle.
- Frame FSM (one bit per falling edge):
  - IDLE: leaves for DATA only if the start bit = 0; a start bit of 1 is ignored.
  - DATA: 8 bits, LSB first.
  - PARITY: the parity bit must make the total of data plus parity odd.
  - STOP: the stop bit must = 1.
  - STOP -> IDLE, emitting the byte if parity and stop are good. Otherwise no byte is emitted and frame_err pulses.
- Timeout:
  - A watchdog counts cycles while the FSM is not IDLE and resets on every falling edge.
  - On reaching TIMEOUT_CYCLES: go to IDLE, discard the partial frame, pulse frame_err.
- Byte decoder, for each good byte:
  - 0xE0: set `ext`.
  - 0xF0: set `brk`.
  - Any other byte with brk or ext set:
    - If brk=1 and the code equals `held`, clear `held`.
    - Then clear brk and ext; no output.
  - Plain make code equal to `held`: typematic repeat, ignored.
  - Plain make code that is mapped: set `held` = code and accept the key.
  - Plain make code that is unmapped: ignored; `held` is unchanged.
- Scan-code map to ASCII (uppercase):
  - A 1C, B 32, C 21, D 23, E 24, F 2B, G 34
  - H 33, I 43, J 3B, K 42, L 4B, M 3A, N 31
  - O 44, P 4D, Q 15, R 2D, S 1B, T 2C, U 3C
  - V 2A, W 1D, X 22, Y 35, Z 1A
  - space 29 -> 0x20
- Accept:
  - Registered the cycle after the byte completes: letter <= ascii, counter <= min(counter+1, MAX_COUNT), key_valid=1 for that one cycle.
  - The first key after a clear yields counter=1.
  - At saturation, letter still updates and key_valid still pulses; counter holds at MAX_COUNT.
- Clear: lvl_won=1 sampled high -> counter <= 0, letter <= 0x00, held cleared.
  - An accept in the same cycle is dropped (no key_valid).
  - A level-sensitive lvl_won holds the block cleared.
  - The frame FSM keeps running during a clear.
- Reset mid-frame: the FSM returns to IDLE; a frame that was in flight is lost without frame_err.

Optional Feature:
- Macro: PS2_BACKSPACE_EN.
- Defined: scan code 0x66 (backspace) is a mapped key.
  - On accept: counter <= counter-1, floored at 0; letter <= 0x08; key_valid pulses.
  - It uses the same held/typematic rules as other keys.
- Undefined: 0x66 is unmapped and ignored.

Test Plan:
- Good frame 0x32 (start 0, bits 0,1,0,0,1,1,0,0, parity 0, stop 1) -> one key_valid pulse, letter=0x42, counter=1, frame_err=0.
- Sequence 32,32,32,F0,32,32 -> exactly 2 accepts, counter=2, letter=0x42.
- Frame 0x3C with parity bit flipped -> frame_err pulses once; counter and letter unchanged; next good 0x3C -> letter=0x55.
- Typematic and break handling: 16 distinct press/release pairs (1C,F0,1C,32,F0,32,...) -> counter sequence 1..15, then holds at 15; key_valid pulses 16 times.
- Clearing: counter=5, pulse lvl_won one cycle -> counter=0, letter=0x00; next 0x29 -> letter=0x20, counter=1. lvl_won asserted in the accept cycle -> no key_valid, counter=0.
- Extended codes: E0,75 and E0,F0,75 -> no accepts. Stop clock after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse, FSM in IDLE, the next full frame decodes correctly.
